game_timer_sched: RTL and testbench
===================================

# game_timer_sched

Four-channel programmable countdown-timer scheduler for the game logic. It contains its own seconds prescaler and accepts LOAD/START/PAUSE/CLEAR commands over a valid/ready port. It decrements all running channels once per tick and reports expirations through a round-robin-arbitrated, one-entry event output buffer. Game FSMs (round timer, power-up timers, etc.) share this one block instead of each instantiating its own counter.

## Interface
- TICK_CYCLES, 25000000, clk cycles per tick; must be ≥ 2.
- CNT_W, 8, width of each channel's remaining count.
- NCH, 4, number of channels; fixed at 4 for this revision, so channel indices are 2 bits.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid.
- cmd_op  in  2  command: 00 LOAD, 01 START, 10 PAUSE, 11 CLEAR.
- cmd_ch  in  2  target channel.
- cmd_data  in  CNT_W  LOAD value; ignored for other ops.
- evt_valid  out  1  expiration event presented.
- evt_ready  in  1  consumer accepts event.
- evt_ch  out  2  channel of the presented event.
- evt_overrun  out  1  sticky: an expiry was merged into an already-pending event.
- tick  out  1  one-cycle tick strobe.
- running  out  NCH  per-channel run flag.
- remaining  out  NCH*CNT_W  channel k occupies bits [k*CNT_W +: CNT_W].

## Operation
- Prescaler:
  - Counts 0..TICK_CYCLES-1, then wraps to 0.
  - tick = (prescaler == TICK_CYCLES-1), combinational from the register.
- cmd_ready = !tick. Commands are never accepted on a tick cycle, so a command and a decrement can never collide.
- Command effects on an accepted command (cmd_valid & cmd_ready), applied at the next edge:
  - LOAD: remaining[ch] ← cmd_data. running is unchanged.
  - START: running[ch] ← 1 if remaining[ch] ≠ 0; otherwise no-op.
  - PAUSE: running[ch] ← 0.
  - CLEAR: remaining[ch] ← 0, running[ch] ← 0, pending[ch] ← 0. An event already in the output buffer is not retracted.
- On a tick edge, for every channel with running = 1:
  - remaining decrements by 1.
  - If remaining was 1: running ← 0 and pending ← 1.
  - If pending was already 1: pending stays 1 and evt_overrun ← 1.
- Non-running channels hold their value. A running channel never sits at 0.
- Event buffer (evt_valid, evt_ch):
  - It is free when evt_valid = 0, or when evt_valid & evt_ready in this cycle.
  - While free and any pending bit is set, it loads the first pending channel found searching from rr upward, mod 4.
  - On load: clear that channel's pending bit, set rr ← ch+1 mod 4.
  - While the buffer is free and nothing is pending, evt_valid drops to 0 at the edge.
  - evt_ch is stable while evt_valid = 1 and evt_ready = 0.
- evt_overrun is cleared only by rst.
- Reset values:
  - prescaler 0, remaining 0, running 0, pending 0, rr 0.
  - evt_valid 0, evt_ch 0, evt_overrun 0.
  - Consequently tick 0 and cmd_ready 1 after reset.
- Reset mid-operation discards all counts, pending events and the buffered event.

## Timing
- A command accepted in cycle N is visible on running/remaining in cycle N+1.
- Tick in cycle T:
  - Decrement is visible in T+1.
  - An expiring channel shows pending in T+1, and evt_valid = 1 in T+2 if the buffer is free.
- Back-to-back events: with evt_ready held high, the buffer reloads in the same cycle it is accepted, giving one event per cycle.
- LOAD, START, PAUSE and CLEAR each take 1 cycle. An accepted START is decremented on the first tick after it.
- A channel loaded with value V and started before tick k expires at tick k+V-1, i.e. V ticks after start.

## Test plan
All scenarios use TICK_CYCLES=4, CNT_W=8.
- Reset, then idle 12 cycles:
  - tick pulses every 4th cycle.
  - cmd_ready is low exactly on tick cycles.
  - All outputs otherwise at reset values.
- LOAD ch2=3, START ch2, evt_ready=1:
  - remaining[2] steps 3,2,1,0 on successive ticks.
  - running[2] falls with the 3rd tick.
  - evt_valid is high for exactly 1 cycle with evt_ch=2, two cycles after that tick.
- Channels 0–3 all loaded to 1 and started, evt_ready=0 until all four are pending:
  - Holding evt_ready=0 afterwards, evt_ch stays 0.
  - Then raising evt_ready gives events in order 0,1,2,3 on consecutive cycles, after which evt_valid=0.
- Round-robin: after an event from ch1 is consumed, ch0 and ch3 expire on the same tick → order 3 then 0.
- Edge commands:
  - START on a channel with remaining=0 leaves running=0.
  - PAUSE mid-count holds remaining across 3 ticks; START resumes.
  - cmd_valid held across a tick cycle is accepted on the following cycle.
- Overrun and reset:
  - Hold evt_ready=0 with ch0 presented, reload/restart ch1 with 1 so it expires twice → evt_overrun=1, and only one ch1 event is delivered.
  - Assert rst while evt_valid=1 → evt_valid=0, evt_overrun=0 and all remaining=0 in the next cycle.

Source files
------------

// File: rtl/game_timer_sched_if.sv
// Command and expiry-event port bundle for game_timer_sched.
// Both channels use valid/ready: a transfer happens on the rising edge where valid and ready are both high.
// The producer holds its payload stable while valid is high and ready is low.
interface game_timer_sched_if #(
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_ch;
  logic [CNT_W-1:0] cmd_data;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_ch;
  logic             evt_overrun;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_data, evt_ready,
    input  cmd_ready, evt_valid, evt_ch, evt_overrun
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_data, evt_ready,
    output cmd_ready, evt_valid, evt_ch, evt_overrun
  );
endinterface

// File: rtl/game_timer_sched.sv
// Four-channel countdown-timer scheduler with built-in tick prescaler and
// round-robin arbitrated one-entry expiry event buffer.
module game_timer_sched #(
  parameter int TICK_CYCLES = 25000000,
  parameter int CNT_W       = 8,
  parameter int NCH         = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  game_timer_sched_if.slave      bus,
  output logic                   tick,
  output logic [NCH-1:0]         running,
  output logic [NCH*CNT_W-1:0]   remaining
);
  localparam int PW = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_START = 2'b01,
    OP_PAUSE = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] rem_q [NCH];
  logic [CNT_W-1:0] rem_d [NCH];
  logic [NCH-1:0]   run_q, run_d;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [1:0]       rr_q, rr_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_ch_q, evt_ch_d;
  logic             ovr_q, ovr_d;

  logic             cmd_fire;
  logic             buf_free;
  logic             sel_found;
  logic [1:0]       sel_ch;

  assign tick          = (presc_q == PW'(TICK_CYCLES - 1));
  assign bus.cmd_ready = !tick;
  assign cmd_fire      = bus.cmd_valid && !tick;
  assign buf_free      = !evt_valid_q || bus.evt_ready;

  assign bus.evt_valid   = evt_valid_q;
  assign bus.evt_ch      = evt_ch_q;
  assign bus.evt_overrun = ovr_q;
  assign running         = run_q;

  always_comb begin
    remaining = '0;
    for (int k = 0; k < NCH; k++) begin
      remaining[k*CNT_W +: CNT_W] = rem_q[k];
    end
  end

  // Highest offset is visited first so the nearest pending channel after rr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[rr_q + 2'(i)]) begin
        sel_found = 1'b1;
        sel_ch    = rr_q + 2'(i);
      end
    end
  end

  always_comb begin
    presc_d     = tick ? '0 : presc_q + PW'(1);
    rem_d       = rem_q;
    run_d       = run_q;
    pend_d      = pend_q;
    rr_d        = rr_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    ovr_d       = ovr_q;

    if (cmd_fire) begin
      case (bus.cmd_op)
        OP_LOAD:  rem_d[bus.cmd_ch] = bus.cmd_data;
        OP_START: if (rem_q[bus.cmd_ch] != '0) run_d[bus.cmd_ch] = 1'b1;
        OP_PAUSE: run_d[bus.cmd_ch] = 1'b0;
        OP_CLEAR: begin
          rem_d[bus.cmd_ch]  = '0;
          run_d[bus.cmd_ch]  = 1'b0;
          pend_d[bus.cmd_ch] = 1'b0;
        end
        default: ;
      endcase
    end

    if (buf_free) begin
      if (sel_found) begin
        evt_valid_d    = 1'b1;
        evt_ch_d       = sel_ch;
        pend_d[sel_ch] = 1'b0;
        rr_d           = sel_ch + 2'd1;
      end else begin
        evt_valid_d = 1'b0;
      end
    end

    // Expiry sees pending after the buffer load, so a channel handed to the
    // buffer this cycle does not count as an overrun.
    if (tick) begin
      for (int k = 0; k < NCH; k++) begin
        if (run_q[k]) begin
          rem_d[k] = rem_q[k] - CNT_W'(1);
          if (rem_q[k] == CNT_W'(1)) begin
            run_d[k] = 1'b0;
            if (pend_d[k]) ovr_d = 1'b1;
            pend_d[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      run_q       <= '0;
      pend_q      <= '0;
      rr_q        <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      ovr_q       <= 1'b0;
      for (int k = 0; k < NCH; k++) rem_q[k] <= '0;
    end else begin
      presc_q     <= presc_d;
      run_q       <= run_d;
      pend_q      <= pend_d;
      rr_q        <= rr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      ovr_q       <= ovr_d;
      for (int k = 0; k < NCH; k++) rem_q[k] <= rem_d[k];
    end
  end
endmodule

// File: tb/tb_game_timer_sched.sv
// Self-checking bench for game_timer_sched: directed command sequences with a
// queue of expected event channels checked as events are consumed.
module tb_game_timer_sched;
  localparam int TICK_CYCLES = 4;
  localparam int CNT_W       = 8;
  localparam int NCH         = 4;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_PAUSE = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 tick;
  logic [NCH-1:0]       running;
  logic [NCH*CNT_W-1:0] remaining;

  game_timer_sched_if #(.CNT_W(CNT_W)) bus();

  game_timer_sched #(
    .TICK_CYCLES (TICK_CYCLES),
    .CNT_W       (CNT_W),
    .NCH         (NCH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .tick      (tick),
    .running   (running),
    .remaining (remaining)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [CNT_W-1:0] rem_of(input int k);
    return remaining[k*CNT_W +: CNT_W];
  endfunction

  // scoreboard: every consumed event must match the head of exp_q
  always @(negedge clk) begin
    if (!rst && bus.evt_valid && bus.evt_ready) begin
      mon_exp = 32'hDEAD;
      if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      check("evt_ch", {30'd0, bus.evt_ch}, mon_exp);
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [1:0] op, input logic [1:0] ch, input logic [CNT_W-1:0] data);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ch    = ch;
    bus.cmd_data  = data;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = $urandom_range(0, 255);
    check("cmd_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 3 * TICK_CYCLES; n++) begin
      @(negedge clk);
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
    check("tick_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_evt();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 8 * TICK_CYCLES; n++) begin
      @(negedge clk);
      if (bus.evt_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("evt_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_ch    = 2'd0;
    bus.cmd_data  = '0;
    bus.evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state and idle tick cadence
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("idle_tick", {31'd0, tick}, {31'd0, (i % 4) == 3});
      check("idle_cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, (i % 4) != 3});
      check("idle_evt_valid", {31'd0, bus.evt_valid}, 32'd0);
      check("idle_running", {28'd0, running}, 32'd0);
      if (i == 0) begin
        check("rst_remaining", remaining, 32'd0);
        check("rst_evt_ch", {30'd0, bus.evt_ch}, 32'd0);
        check("rst_overrun", {31'd0, bus.evt_overrun}, 32'd0);
      end
    end

    // single channel countdown with immediate consumer
    bus.evt_ready = 1'b1;
    send_cmd(OP_LOAD, 2'd2, 8'd3);
    check("load_rem2", rem_of(2), 32'd3);
    check("load_keeps_run2", {31'd0, running[2]}, 32'd0);
    send_cmd(OP_START, 2'd2, 8'd0);
    check("start_run2", {31'd0, running[2]}, 32'd1);
    exp_q.push_back(32'd2);
    for (int i = 0; i < 3; i++) begin
      wait_tick();
      @(posedge clk); #1;
      check("step_rem2", rem_of(2), 32'(2 - i));
      check("step_run2", {31'd0, running[2]}, {31'd0, i != 2});
    end
    @(negedge clk);
    check("evt_not_yet", {31'd0, bus.evt_valid}, 32'd0);
    @(negedge clk);
    check("evt_t2_valid", {31'd0, bus.evt_valid}, 32'd1);
    @(negedge clk);
    check("evt_one_cycle", {31'd0, bus.evt_valid}, 32'd0);
    check("q_empty_single", exp_q.size(), 32'd0);

    // all four pending, stalled consumer then burst drain
    bus.evt_ready = 1'b0;
    for (int c = 0; c < 4; c++) send_cmd(OP_LOAD, 2'(c), 8'd1);
    for (int c = 0; c < 4; c++) send_cmd(OP_START, 2'(c), 8'd0);
    wait_tick();
    wait_tick();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, bus.evt_valid}, 32'd1);
      check("stall_ch", {30'd0, bus.evt_ch}, 32'd0);
      check("stall_running", {28'd0, running}, 32'd0);
    end
    for (int c = 0; c < 4; c++) exp_q.push_back(32'(c));
    @(posedge clk); #1;
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("burst_valid", {31'd0, bus.evt_valid}, 32'd1);
    end
    @(negedge clk);
    check("burst_done", {31'd0, bus.evt_valid}, 32'd0);
    check("q_empty_burst", exp_q.size(), 32'd0);

    // round robin: after ch1 is consumed, ch3 beats ch0
    send_cmd(OP_LOAD, 2'd1, 8'd1);
    send_cmd(OP_START, 2'd1, 8'd0);
    exp_q.push_back(32'd1);
    repeat (3 * TICK_CYCLES) @(posedge clk);
    check("q_empty_ch1", exp_q.size(), 32'd0);
    send_cmd(OP_LOAD, 2'd0, 8'd1);
    send_cmd(OP_LOAD, 2'd3, 8'd1);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd0);
    wait_tick();
    send_cmd(OP_START, 2'd0, 8'd0);
    send_cmd(OP_START, 2'd3, 8'd0);
    repeat (3 * TICK_CYCLES) @(posedge clk);
    check("q_empty_rr", exp_q.size(), 32'd0);

    // START on an empty channel is a no-op
    send_cmd(OP_START, 2'd1, 8'd0);
    check("start_zero_run1", {31'd0, running[1]}, 32'd0);

    // pause holds the count across ticks, start resumes
    send_cmd(OP_LOAD, 2'd0, 8'd5);
    send_cmd(OP_START, 2'd0, 8'd0);
    wait_tick();
    @(posedge clk); #1;
    check("pause_pre_rem0", rem_of(0), 32'd4);
    send_cmd(OP_PAUSE, 2'd0, 8'd0);
    check("pause_run0", {31'd0, running[0]}, 32'd0);
    repeat (3) wait_tick();
    @(posedge clk); #1;
    check("pause_hold_rem0", rem_of(0), 32'd4);
    send_cmd(OP_START, 2'd0, 8'd0);
    check("resume_run0", {31'd0, running[0]}, 32'd1);
    wait_tick();
    @(posedge clk); #1;
    check("resume_rem0", rem_of(0), 32'd3);
    send_cmd(OP_CLEAR, 2'd0, 8'd0);
    check("clear_rem0", rem_of(0), 32'd0);
    check("clear_run0", {31'd0, running[0]}, 32'd0);

    // command held across a tick cycle lands one cycle later
    wait_tick();
    repeat (4) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LOAD;
    bus.cmd_ch    = 2'd3;
    bus.cmd_data  = 8'd7;
    @(negedge clk);
    check("held_ready_on_tick", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("held_not_taken", rem_of(3), 32'd0);
    @(negedge clk);
    check("held_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("held_taken", rem_of(3), 32'd7);
    send_cmd(OP_CLEAR, 2'd3, 8'd0);

    // overrun: ch1 expires twice while the buffer is blocked by ch0
    bus.evt_ready = 1'b0;
    send_cmd(OP_LOAD, 2'd0, 8'd1);
    send_cmd(OP_START, 2'd0, 8'd0);
    exp_q.push_back(32'd0);
    wait_evt();
    send_cmd(OP_LOAD, 2'd1, 8'd1);
    send_cmd(OP_START, 2'd1, 8'd0);
    exp_q.push_back(32'd1);
    wait_tick();
    wait_tick();
    check("ovr_not_yet", {31'd0, bus.evt_overrun}, 32'd0);
    send_cmd(OP_LOAD, 2'd1, 8'd1);
    send_cmd(OP_START, 2'd1, 8'd0);
    wait_tick();
    wait_tick();
    @(posedge clk); #1;
    check("ovr_set", {31'd0, bus.evt_overrun}, 32'd1);
    check("ovr_buf_valid", {31'd0, bus.evt_valid}, 32'd1);
    check("ovr_buf_ch", {30'd0, bus.evt_ch}, 32'd0);
    bus.evt_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("q_empty_ovr", exp_q.size(), 32'd0);
    check("ovr_drained", {31'd0, bus.evt_valid}, 32'd0);
    check("ovr_sticky", {31'd0, bus.evt_overrun}, 32'd1);

    // reset while an event is presented
    bus.evt_ready = 1'b0;
    send_cmd(OP_LOAD, 2'd2, 8'd1);
    send_cmd(OP_START, 2'd2, 8'd0);
    send_cmd(OP_LOAD, 2'd3, 8'd9);
    send_cmd(OP_START, 2'd3, 8'd0);
    wait_evt();
    check("pre_rst_valid", {31'd0, bus.evt_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_valid", {31'd0, bus.evt_valid}, 32'd0);
    check("rst_mid_overrun", {31'd0, bus.evt_overrun}, 32'd0);
    check("rst_mid_remaining", remaining, 32'd0);
    check("rst_mid_running", {28'd0, running}, 32'd0);
    check("rst_mid_tick", {31'd0, tick}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.cmd_ready}, 32'd1);
    exp_q.delete();
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
